// File: rtl/papuf_pkg.sv
// Shared types and width helpers for the PAPUF evaluation controller.
// Included by the top and by the per-bit vote accumulator.
package papuf_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FIRE  = 2'd1,
    RELAX = 2'd2,
    DONE  = 2'd3
  } eval_state_t;

  // Vote counter must hold 0..VOTE_N.
  function automatic int cnt_w(input int vote_n);
    return $clog2(vote_n + 1);
  endfunction

  // Round counter must hold 0..VOTE_N.
  function automatic int round_w(input int vote_n);
    return $clog2(vote_n + 1);
  endfunction

  function automatic bit params_ok(input int n_resp, input int settle_cyc, input int vote_n);
    return (vote_n % 2 == 1) && (vote_n >= 1) && (settle_cyc >= 3) &&
           (n_resp % 2 == 0) && (n_resp >= 2);
  endfunction

endpackage

// File: rtl/papuf_vote_acc.sv
// Per-bit majority accumulator: counts high samples of one synchronised PUF bit
// and reports the majority vote and whether every sample agreed.
module papuf_vote_acc
  import papuf_pkg::*;
#(
  parameter int VOTE_N = 5,
  parameter int CW     = cnt_w(VOTE_N)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic sample,
  input  logic din,
  output logic vote,
  output logic stable
);

  logic [CW-1:0] cnt_r;

  // Count high samples; clear has priority over a coincident sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (clear) begin
      cnt_r <= '0;
    end else if (sample && din) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign vote   = (cnt_r > CW'(VOTE_N / 2));
  assign stable = (cnt_r == CW'(0)) || (cnt_r == CW'(VOTE_N));

endmodule

// File: rtl/papuf_eval_ctrl.sv
// PAPUF evaluation controller: holds the challenge, fires the array VOTE_N times,
// majority-votes the synchronised responses and reports a per-bit stability mask.
module papuf_eval_ctrl
  import papuf_pkg::*;
#(
  parameter int N_RESP     = 16,
  parameter int CHAL_W     = 16,
  parameter int SETTLE_CYC = 8,
  parameter int VOTE_N     = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [CHAL_W-1:0] challenge,
  input  logic              xor_mode,
  output logic [CHAL_W-1:0] chal_out,
  output logic              puf_pulse,
  input  logic [N_RESP-1:0] puf_resp,
  output logic              busy,
  output logic              done,
  output logic [N_RESP-1:0] response,
  output logic [N_RESP-1:0] stable
);

  localparam int PW = $clog2(SETTLE_CYC);
  localparam int RW = round_w(VOTE_N);
  localparam logic [PW-1:0] PH_LAST    = PW'(SETTLE_CYC - 1);
  localparam logic [RW-1:0] ROUND_LAST = RW'(VOTE_N - 1);

  if (!params_ok(N_RESP, SETTLE_CYC, VOTE_N)) begin : g_bad_params
    $error("papuf_eval_ctrl: need VOTE_N odd, SETTLE_CYC>=3, N_RESP even");
  end

  eval_state_t       state_r, state_s;
  logic [PW-1:0]     phase_r;
  logic [RW-1:0]     round_r;
  logic              xor_r;
  logic [N_RESP-1:0] sync1_r, sync2_r;
  logic [CHAL_W-1:0] chal_out_r;
  logic              puf_pulse_r, busy_r, done_r;
  logic [N_RESP-1:0] response_r, stable_r;
  logic              accept_s, abort_s, sample_s, phase_last_s, clear_s;
  logic [N_RESP-1:0] vote_s, stab_s, fold_s, result_s;

  // Next-state decode; abort is honoured only while the array is being exercised.
  always_comb begin
    state_s      = state_r;
    accept_s     = 1'b0;
    abort_s      = 1'b0;
    sample_s     = 1'b0;
    phase_last_s = (phase_r == PH_LAST);
    case (state_r)
      IDLE: begin
        if (start && !abort) begin
          state_s  = FIRE;
          accept_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      FIRE: begin
        if (abort) begin
          state_s = IDLE;
          abort_s = 1'b1;
        end else if (phase_last_s) begin
          state_s  = RELAX;
          sample_s = 1'b1;
        end else begin
          state_s = FIRE;
        end
      end
      RELAX: begin
        if (abort) begin
          state_s = IDLE;
          abort_s = 1'b1;
        end else if (phase_last_s) begin
          state_s = (round_r == ROUND_LAST) ? DONE : FIRE;
        end else begin
          state_s = RELAX;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  assign clear_s = accept_s | abort_s;

  for (genvar i = 0; i < N_RESP; i++) begin : g_bit
    papuf_vote_acc #(.VOTE_N(VOTE_N)) u_acc (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (clear_s),
      .sample (sample_s),
      .din    (sync2_r[i]),
      .vote   (vote_s[i]),
      .stable (stab_s[i])
    );
    assign fold_s[i] = vote_s[i] ^ vote_s[N_RESP-1-i];
  end

  assign result_s = xor_r ? fold_s : vote_s;

  // Control state, counters, synchroniser and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      phase_r     <= '0;
      round_r     <= '0;
      xor_r       <= 1'b0;
      sync1_r     <= '0;
      sync2_r     <= '0;
      chal_out_r  <= '0;
      puf_pulse_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      response_r  <= '0;
      stable_r    <= '0;
    end else begin
      state_r     <= state_s;
      sync1_r     <= puf_resp;
      sync2_r     <= sync1_r;
      puf_pulse_r <= (state_s == FIRE);
      done_r      <= (state_r == DONE);
      if (state_s != state_r || (state_r != FIRE && state_r != RELAX)) begin
        phase_r <= '0;
      end else begin
        phase_r <= phase_r + PW'(1);
      end
      if (accept_s) begin
        round_r <= '0;
      end else if (state_r == RELAX && phase_last_s && !abort) begin
        round_r <= round_r + RW'(1);
      end else begin
        round_r <= round_r;
      end
      if (accept_s) begin
        chal_out_r <= challenge;
        xor_r      <= xor_mode;
        busy_r     <= 1'b1;
      end else if (abort_s || state_r == DONE) begin
        busy_r <= 1'b0;
      end else begin
        busy_r <= busy_r;
      end
      // Results are captured only on completion, so an abort leaves them intact.
      if (state_r == DONE) begin
        response_r <= result_s;
        stable_r   <= stab_s;
      end else begin
        response_r <= response_r;
        stable_r   <= stable_r;
      end
    end
  end

  assign chal_out  = chal_out_r;
  assign puf_pulse = puf_pulse_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign response  = response_r;
  assign stable    = stable_r;

endmodule

// File: tb/tb_papuf_eval_ctrl.sv
// Directed self-checking bench for papuf_eval_ctrl at default parameters.
module tb_papuf_eval_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] challenge = 16'h0000;
  logic        xor_mode = 1'b0;
  logic [15:0] chal_out;
  logic        puf_pulse;
  logic [15:0] puf_resp = 16'h0000;
  logic        busy;
  logic        done;
  logic [15:0] response;
  logic [15:0] stable;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int cyc;
  int d0;

  papuf_eval_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .challenge (challenge),
    .xor_mode  (xor_mode),
    .chal_out  (chal_out),
    .puf_pulse (puf_pulse),
    .puf_resp  (puf_resp),
    .busy      (busy),
    .done      (done),
    .response  (response),
    .stable    (stable)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start an evaluation and follow it cycle by cycle; cyc = cycles from accept to done (999 if none).
  task automatic run_eval(input logic [15:0] chal, input logic xm, input logic [4:0][15:0] pats,
                          input int abort_at, input int restart_at, output int cyc_o);
    int n;
    @(negedge clk);
    start = 1'b1; challenge = chal; xor_mode = xm;
    @(posedge clk); #1;
    start = 1'b0; puf_resp = pats[0];
    n = 0; cyc_o = 999;
    while (n < 300) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) begin
        chk("busy_on", {31'd0, busy}, 32'd1);
        chk("pulse_on", {31'd0, puf_pulse}, 32'd1);
      end
      if (n == 8) chk("pulse_relax", {31'd0, puf_pulse}, 32'd0);
      if (abort_at > 0 && n == abort_at) chk("pulse_pre_abort", {31'd0, puf_pulse}, 32'd1);
      if (abort_at > 0 && n == abort_at + 1) begin
        chk("pulse_abort", {31'd0, puf_pulse}, 32'd0);
        chk("busy_abort", {31'd0, busy}, 32'd0);
      end
      if (done === 1'b1) begin
        cyc_o = n;
        break;
      end
      start = (n == restart_at) ? 1'b1 : 1'b0;
      if (n == restart_at) challenge = ~chal;
      abort = (abort_at > 0 && n == abort_at) ? 1'b1 : 1'b0;
      if (n % 16 == 0 && n / 16 < 5) puf_resp = pats[n / 16];
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic chk_result(input string tag, input int c, input logic [15:0] chal,
                            input logic [15:0] resp, input logic [15:0] stab);
    chk({tag, "_latency"}, c, 32'd81);
    chk({tag, "_response"}, {16'd0, response}, {16'd0, resp});
    chk({tag, "_stable"}, {16'd0, stable}, {16'd0, stab});
    chk({tag, "_chal_out"}, {16'd0, chal_out}, {16'd0, chal});
    @(posedge clk); #1;
    chk({tag, "_done_strobe"}, {31'd0, done}, 32'd0);
    chk({tag, "_busy_off"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_chal_out", {16'd0, chal_out}, 32'd0);
    chk("rst_pulse", {31'd0, puf_pulse}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_response", {16'd0, response}, 32'd0);
    chk("rst_stable", {16'd0, stable}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // 1: constant response
    run_eval(16'h1234, 1'b0, {5{16'hA5C3}}, 0, 0, cyc);
    chk_result("t1", cyc, 16'h1234, 16'hA5C3, 16'hFFFF);

    // 2: bit0 high in 3 of 5, then 2 of 5
    run_eval(16'h0001, 1'b0, {16'h0001, 16'h0000, 16'h0001, 16'h0000, 16'h0001}, 0, 0, cyc);
    chk_result("t2a", cyc, 16'h0001, 16'h0001, 16'hFFFE);
    run_eval(16'h0002, 1'b0, {16'h0000, 16'h0001, 16'h0000, 16'h0001, 16'h0000}, 0, 0, cyc);
    chk_result("t2b", cyc, 16'h0002, 16'h0000, 16'hFFFE);

    // 3: XOR fold
    run_eval(16'h0003, 1'b1, {5{16'h00FF}}, 0, 0, cyc);
    chk_result("t3", cyc, 16'h0003, 16'hFFFF, 16'hFFFF);

    // 4: start and challenge change while busy
    d0 = done_cnt;
    run_eval(16'hBEEF, 1'b0, {5{16'h0F0F}}, 0, 10, cyc);
    chk_result("t4", cyc, 16'hBEEF, 16'h0F0F, 16'hFFFF);
    repeat (5) @(posedge clk);
    #1;
    chk("t4_no_requeue", {31'd0, busy}, 32'd0);
    chk("t4_single_done", done_cnt, d0 + 1);

    // 5: abort mid-evaluation, then a normal run
    d0 = done_cnt;
    run_eval(16'hCAFE, 1'b0, {5{16'hFFFF}}, 20, 0, cyc);
    chk("t5_no_done", cyc, 32'd999);
    chk("t5_done_cnt", done_cnt, d0);
    chk("t5_resp_kept", {16'd0, response}, 32'h0000_0F0F);
    chk("t5_stab_kept", {16'd0, stable}, 32'h0000_FFFF);
    run_eval(16'hCAFE, 1'b0, {5{16'hFFFF}}, 0, 0, cyc);
    chk_result("t5b", cyc, 16'hCAFE, 16'hFFFF, 16'hFFFF);

    // abort together with start in IDLE: no start
    @(negedge clk); start = 1'b1; abort = 1'b1; challenge = 16'h5555;
    @(posedge clk); #1; start = 1'b0; abort = 1'b0;
    chk("abort_start_busy", {31'd0, busy}, 32'd0);
    chk("abort_start_pulse", {31'd0, puf_pulse}, 32'd0);
    chk("abort_start_chal", {16'd0, chal_out}, 32'h0000_CAFE);

    // 6: asynchronous reset mid-FIRE
    @(negedge clk); start = 1'b1; challenge = 16'h7777;
    @(posedge clk); #1; start = 1'b0; puf_resp = 16'h3C3C;
    repeat (3) @(posedge clk);
    #1;
    chk("t6_pulse_pre", {31'd0, puf_pulse}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_pulse_async", {31'd0, puf_pulse}, 32'd0);
    chk("t6_busy", {31'd0, busy}, 32'd0);
    chk("t6_chal_out", {16'd0, chal_out}, 32'd0);
    chk("t6_response", {16'd0, response}, 32'd0);
    chk("t6_stable", {16'd0, stable}, 32'd0);
    chk("t6_done", {31'd0, done}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_eval(16'h9876, 1'b0, {5{16'h3C3C}}, 0, 0, cyc);
    chk_result("t6b", cyc, 16'h9876, 16'h3C3C, 16'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
